// File: rtl/fft_bin_writer.sv
// Captures one frame of complex FFT bins from a valid/ready stream into the spectrum RAM (re at k, im at k+N).
// Optional FFT_BITREV_EN: write base address is the bit-reversal of the arrival index (natural-order output).
module fft_bin_writer #(
   parameter int unsigned DATA_W = 10,
   parameter int unsigned N_LOG2 = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_re,
   input  logic [DATA_W-1:0] i_in_im,
   input  logic              i_in_last,
   output logic              o_mem_we,
   output logic [N_LOG2:0]   o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_frame_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RECV  = 2'd1;
   localparam logic [1:0] S_WR_IM = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [N_LOG2-1:0] BIN_LAST = '1;
   localparam logic [N_LOG2-1:0] BIN_ONE  = {{(N_LOG2-1){1'b0}}, 1'b1};

   logic [1:0]        r_state,      w_state;
   logic [N_LOG2-1:0] r_bin,        w_bin;
   logic [DATA_W-1:0] r_im,         w_im;
   logic              r_last,       w_last;
   logic              r_mem_we,     w_mem_we;
   logic [N_LOG2:0]   r_mem_addr,   w_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata,  w_mem_wdata;
   logic              r_busy,       w_busy;
   logic              r_frame_done, w_frame_done;
   logic              r_frame_err,  w_frame_err;
   logic [N_LOG2-1:0] w_base;

   // RAM base address for the current bin
`ifdef FFT_BITREV_EN
   always_comb begin
      w_base = '0;
      for (int unsigned i = 0; i < N_LOG2; i++) begin
         w_base[i] = r_bin[N_LOG2-1-i];
      end
   end
`else
   always_comb begin
      w_base = r_bin;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_bin        <= '0;
         r_im         <= '0;
         r_last       <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_state      <= w_state;
         r_bin        <= w_bin;
         r_im         <= w_im;
         r_last       <= w_last;
         r_mem_we     <= w_mem_we;
         r_mem_addr   <= w_mem_addr;
         r_mem_wdata  <= w_mem_wdata;
         r_busy       <= w_busy;
         r_frame_done <= w_frame_done;
         r_frame_err  <= w_frame_err;
      end
   end

   // Next state and next registered outputs; the imag write also decides frame end
   always_comb begin
      w_state      = r_state;
      w_bin        = r_bin;
      w_im         = r_im;
      w_last       = r_last;
      w_mem_we     = 1'b0;
      w_mem_addr   = r_mem_addr;
      w_mem_wdata  = r_mem_wdata;
      w_frame_done = r_frame_done;
      w_frame_err  = r_frame_err;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_state      = S_RECV;
               w_bin        = '0;
               w_frame_done = 1'b0;
               w_frame_err  = 1'b0;
            end
         end
         S_RECV: begin
            if (i_in_valid) begin
               w_mem_we    = 1'b1;
               w_mem_addr  = {1'b0, w_base};
               w_mem_wdata = i_in_re;
               w_im        = i_in_im;
               w_last      = i_in_last;
               w_state     = S_WR_IM;
            end
         end
         S_WR_IM: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = {1'b1, w_base};
            w_mem_wdata = r_im;
            if (r_bin == BIN_LAST) begin
               w_frame_err  = r_frame_err | ~r_last;
               w_frame_done = 1'b1;
               w_state      = S_DONE;
            end else if (r_last) begin
               w_frame_err  = 1'b1;
               w_frame_done = 1'b1;
               w_state      = S_DONE;
            end else begin
               w_bin   = r_bin + BIN_ONE;
               w_state = S_RECV;
            end
         end
         default: w_state = S_IDLE;
      endcase
      w_busy = (w_state == S_RECV) || (w_state == S_WR_IM);
   end

   assign o_in_ready   = (r_state == S_RECV);
   assign o_mem_we     = r_mem_we;
   assign o_mem_addr   = r_mem_addr;
   assign o_mem_wdata  = r_mem_wdata;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;
   assign o_frame_err  = r_frame_err;

endmodule

// File: tb/tb_fft_bin_writer.sv
// Self-checking bench for fft_bin_writer: random frames against a write-list/RAM reference model.
// Build with +define+FFT_BITREV_EN to check the bit-reversed addressing variant.
module tb_fft_bin_writer;

   localparam int unsigned DATA_W = 10;
   localparam int unsigned N_LOG2 = 10;
   localparam int unsigned N      = 1 << N_LOG2;
   localparam int unsigned AW     = N_LOG2 + 1;
   localparam int unsigned EW     = AW + DATA_W;
   localparam logic [DATA_W-1:0] SENT = 10'h155;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_start = 1'b0;
   logic              i_in_valid = 1'b0;
   logic              o_in_ready;
   logic [DATA_W-1:0] i_in_re = '0;
   logic [DATA_W-1:0] i_in_im = '0;
   logic              i_in_last = 1'b0;
   logic              o_mem_we;
   logic [AW-1:0]     o_mem_addr;
   logic [DATA_W-1:0] o_mem_wdata;
   logic              o_busy;
   logic              o_frame_done;
   logic              o_frame_err;

   fft_bin_writer #(.DATA_W(DATA_W), .N_LOG2(N_LOG2)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_in_valid(i_in_valid),
      .o_in_ready(o_in_ready), .i_in_re(i_in_re), .i_in_im(i_in_im),
      .i_in_last(i_in_last), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
      .o_mem_wdata(o_mem_wdata), .o_busy(o_busy), .o_frame_done(o_frame_done),
      .o_frame_err(o_frame_err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   logic [EW-1:0]     obs_q[$];
   logic [EW-1:0]     exp_q[$];
   logic [DATA_W-1:0] dut_ram[2*N];
   logic [DATA_W-1:0] exp_ram[2*N];
   logic [DATA_W-1:0] bin_re[N];
   logic [DATA_W-1:0] bin_im[N];
   bit                bin_last[N];

   // Every RAM write seen on the port
   always @(negedge clk) begin
      if (!rst && o_mem_we) obs_q.push_back({o_mem_addr, o_mem_wdata});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned addr_base(input int unsigned k);
      int unsigned r;
      r = k;
`ifdef FFT_BITREV_EN
      r = 0;
      for (int unsigned i = 0; i < N_LOG2; i++)
         if (((k >> i) & 1) != 0) r = r | (1 << (N_LOG2 - 1 - i));
`endif
      return r;
   endfunction

   // mode 0: re=k, im=-k; mode 1: random. last_pos < 0 means in_last never set.
   task automatic gen_frame(input int mode, input int last_pos);
      for (int k = 0; k < int'(N); k++) begin
         bin_re[k]   = (mode != 0) ? DATA_W'($urandom) : DATA_W'(k);
         bin_im[k]   = (mode != 0) ? DATA_W'($urandom) : DATA_W'(-k);
         bin_last[k] = (k == last_pos);
      end
      bin_re[1] = DATA_W'(7);
      bin_im[1] = DATA_W'(-3);
   endtask

   // Reference: two writes per accepted bin; frame ends at the first in_last or at bin N-1
   task automatic model(output int nb, output bit err);
      int unsigned b;
      exp_q.delete();
      nb  = 0;
      err = 1'b0;
      for (int k = 0; k < int'(N); k++) begin
         b = addr_base(int'(k));
         exp_q.push_back({AW'(b), bin_re[k]});
         exp_q.push_back({AW'(b + N), bin_im[k]});
         exp_ram[b]     = bin_re[k];
         exp_ram[b + N] = bin_im[k];
         nb = k + 1;
         if (bin_last[k] || k == int'(N) - 1) begin
            err = (bin_last[k] != (k == int'(N) - 1));
            break;
         end
      end
   endtask

   task automatic clear_rams();
      for (int a = 0; a < int'(2*N); a++) begin
         dut_ram[a] = SENT;
         exp_ram[a] = SENT;
      end
   endtask

   task automatic do_start();
      @(negedge clk) i_start = 1'b1;
      @(negedge clk) i_start = 1'b0;
      chk("start_busy", 32'(o_busy), 32'd1);
      chk("start_done_clr", 32'(o_frame_done), 32'd0);
   endtask

   // gap 0: valid always; 1: every 3rd cycle; 2: random with stray start pulses
   task automatic stream(input int nb, input int gap, output int fh, output int lh, output bit to);
      int  k;
      int  budget;
      bit  v;
      bit  hs;
      k = 0; budget = 0; fh = 0; lh = 0;
      while (k < nb && budget < 20000) begin
         @(negedge clk);
         v = (gap == 0) ? 1'b1 : (gap == 1) ? ((cyc % 3) == 0) : ($urandom_range(0, 3) != 0);
         i_start    = (gap == 2) && ($urandom_range(0, 15) == 0);
         i_in_valid = v;
         i_in_re    = bin_re[k];
         i_in_im    = bin_im[k];
         i_in_last  = bin_last[k];
         hs = v && o_in_ready;
         if (hs) begin
            if (k == 0) fh = int'(cyc);
            lh = int'(cyc);
         end
         @(posedge clk);
         if (hs) k++;
         budget++;
      end
      to = (k < nb);
   endtask

   task automatic wait_done(input bit hold_valid, output int dc, output bit to);
      to = 1'b1;
      dc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         i_in_valid = hold_valid;
         i_start    = 1'b0;
         if (o_frame_done) begin
            dc = int'(cyc);
            to = 1'b0;
            break;
         end
      end
      repeat (4) @(negedge clk);
      i_in_valid = 1'b0;
   endtask

   function automatic int seq_mism(input int ob, input int n);
      int m;
      m = 0;
      for (int i = 0; i < n; i++)
         if (ob + i >= obs_q.size() || obs_q[ob + i] !== exp_q[i]) m++;
      return m;
   endfunction

   task automatic check_frame(input string tag, input int ob, input bit exp_err);
      logic [EW-1:0] e;
      int m;
      chk({tag, "_wr_count"}, 32'(obs_q.size() - ob), 32'(exp_q.size()));
      chk({tag, "_wr_seq"}, 32'(seq_mism(ob, exp_q.size())), 32'd0);
      for (int i = ob; i < obs_q.size(); i++) begin
         e = obs_q[i];
         dut_ram[e[EW-1:DATA_W]] = e[DATA_W-1:0];
      end
      m = 0;
      for (int a = 0; a < int'(2*N); a++) if (dut_ram[a] !== exp_ram[a]) m++;
      chk({tag, "_ram"}, 32'(m), 32'd0);
      chk({tag, "_done"}, 32'(o_frame_done), 32'd1);
      chk({tag, "_err"}, 32'(o_frame_err), 32'(exp_err));
      chk({tag, "_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_ready"}, 32'(o_in_ready), 32'd0);
   endtask

   initial begin
      int  nb, fh, lh, dc, ob;
      bit  eerr, to;

      #12;
      chk("rst_we", 32'(o_mem_we), 32'd0);
      chk("rst_addr_data", 32'({o_mem_addr, o_mem_wdata}), 32'd0);
      chk("rst_flags", 32'({o_in_ready, o_busy, o_frame_done, o_frame_err}), 32'd0);
      @(negedge clk) rst = 1'b0;
      clear_rams();

      // Full frame at full rate, natural data
      gen_frame(0, int'(N) - 1);
      model(nb, eerr);
      ob = obs_q.size();
      do_start();
      stream(nb, 0, fh, lh, to);
      chk("t1_stream_to", 32'(to), 32'd0);
      wait_done(1'b0, dc, to);
      chk("t1_done_to", 32'(to), 32'd0);
      chk("t1_hs_span", 32'(lh - fh), 32'd2046);
      chk("t1_latency", 32'(dc - fh), 32'd2048);
      check_frame("t1", ob, eerr);
      chk("t1_last_re", 32'(obs_q[ob + 2046]), 32'({11'd1023, 10'h3FF}));
      chk("t1_last_im", 32'(obs_q[ob + 2047]), 32'({11'd2047, 10'h001}));
`ifdef FFT_BITREV_EN
      chk("rev_b1_re", 32'(obs_q[ob + 2]), 32'({11'd512, 10'd7}));
      chk("rev_b1_im", 32'(obs_q[ob + 3]), 32'({11'd1536, 10'h3FD}));
      chk("rev_b2_re_addr", 32'(obs_q[ob + 4] >> DATA_W), 32'd256);
      chk("rev_b2_im_addr", 32'(obs_q[ob + 5] >> DATA_W), 32'd1280);
`else
      chk("nat_b1_re", 32'(obs_q[ob + 2]), 32'({11'd1, 10'd7}));
      chk("nat_b1_im", 32'(obs_q[ob + 3]), 32'({11'd1025, 10'h3FD}));
`endif

      // Same data, valid every third cycle
      gen_frame(0, int'(N) - 1);
      model(nb, eerr);
      ob = obs_q.size();
      do_start();
      stream(nb, 1, fh, lh, to);
      chk("t2_stream_to", 32'(to), 32'd0);
      wait_done(1'b0, dc, to);
      chk("t2_done_after_last", 32'(dc - lh), 32'd2);
      check_frame("t2", ob, eerr);

      // Early in_last on bin 5, valid held high in DONE
      clear_rams();
      gen_frame(1, 5);
      model(nb, eerr);
      ob = obs_q.size();
      do_start();
      stream(nb, 0, fh, lh, to);
      chk("t3_stream_to", 32'(to), 32'd0);
      wait_done(1'b1, dc, to);
      chk("t3_done_to", 32'(to), 32'd0);
      check_frame("t3", ob, eerr);
      chk("t3_nbins", 32'(nb), 32'd6);
      chk("t3_untouched", 32'({dut_ram[addr_base(6)], dut_ram[addr_base(6) + N]}), 32'({SENT, SENT}));

      // Missing in_last, random data and gaps with stray start pulses
      gen_frame(1, -1);
      model(nb, eerr);
      ob = obs_q.size();
      do_start();
      stream(nb, 2, fh, lh, to);
      chk("t4_stream_to", 32'(to), 32'd0);
      wait_done(1'b0, dc, to);
      check_frame("t4", ob, eerr);

      // Reset during the imag write of bin 300
      gen_frame(1, int'(N) - 1);
      model(nb, eerr);
      ob = obs_q.size();
      do_start();
      stream(301, 0, fh, lh, to);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_we", 32'(o_mem_we), 32'd0);
      chk("t5_rst_addr_data", 32'({o_mem_addr, o_mem_wdata}), 32'd0);
      chk("t5_rst_flags", 32'({o_in_ready, o_busy, o_frame_done, o_frame_err}), 32'd0);
      chk("t5_partial_cnt", 32'(obs_q.size() - ob), 32'd600);
      chk("t5_partial_seq", 32'(seq_mism(ob, 600)), 32'd0);
      @(negedge clk);
      @(negedge clk) begin rst = 1'b0; i_in_valid = 1'b0; end
      @(negedge clk);
      chk("t5_idle_flags", 32'({o_busy, o_frame_done, o_frame_err}), 32'd0);

      // Full random frame after reset completes cleanly
      gen_frame(1, int'(N) - 1);
      model(nb, eerr);
      ob = obs_q.size();
      do_start();
      stream(nb, 2, fh, lh, to);
      chk("t6_stream_to", 32'(to), 32'd0);
      wait_done(1'b0, dc, to);
      check_frame("t6", ob, eerr);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
